quad_encoder_bank: RTL

QUAD_ENCODER_BANK -- requirements
Module: quad_encoder_bank

---
 rtl/quad_enc_pkg.sv | 51 +++++
 rtl/quad_enc_channel.sv | 138 +++++++++++++
 rtl/quad_encoder_bank.sv | 119 +++++++++++
 3 files changed

// File: rtl/quad_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quad_enc_pkg
//  Description : Shared definitions for the quadrature encoder bank.
//                Holds the read-field codes and the 4x step decoder used
//                by every channel.
//  Revision    : 1.0 - initial release
// ============================================================================
package quad_enc_pkg;

    // Read-field codes carried in sel[1:0]
    localparam logic [1:0] F_DELTA   = 2'd0;
    localparam logic [1:0] F_SNAPPOS = 2'd1;
    localparam logic [1:0] F_LIVEPOS = 2'd2;
    localparam logic [1:0] F_STATUS  = 2'd3;

    typedef struct packed {
        logic              illegal;
        logic signed [1:0] step;
    } step_t;

    // Position of an AB pair along the forward cycle 00->01->11->10
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Distance along the cycle (mod 4): 1 = forward, 3 = reverse,
    // 2 = both phases moved at once (illegal), 0 = no movement.
    function automatic step_t decode_step(input logic [1:0] prev,
                                          input logic [1:0] cur);
        logic [1:0] diff;
        step_t      r;
        diff      = gray_idx(cur) - gray_idx(prev);
        r.illegal = 1'b0;
        r.step    = 2'sb00;
        case (diff)
            2'd1:    r.step    = 2'sb01;
            2'd3:    r.step    = 2'sb11;
            2'd2:    r.illegal = 1'b1;
            default: r.step    = 2'sb00;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/quad_enc_channel.sv
`default_nettype none
// ============================================================================
//  Module      : quad_enc_channel
//  Description : One quadrature channel: input synchronizer + history,
//                4x decode, saturating window delta, wrapping position,
//                sticky error flag, saturating error counter and the
//                window snapshot registers.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_a, i_b        - raw asynchronous encoder phases
//                i_clr           - clear position / error state
//                i_win_end       - terminal cycle of the sample window
//                o_snap_delta    - delta latched at last window end
//                o_snap_pos      - position latched at last window end
//                o_live_pos      - running position
//                o_err, o_err_cnt- sticky error flag and error count
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_enc_channel
    import quad_enc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_clr,
    input  logic             i_win_end,
    output logic [CNT_W-1:0] o_snap_delta,
    output logic [CNT_W-1:0] o_snap_pos,
    output logic [CNT_W-1:0] o_live_pos,
    output logic             o_err,
    output logic [7:0]       o_err_cnt
);

    localparam logic signed [CNT_W:0] c_delta_max = {2'b00, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W:0] c_delta_min = -c_delta_max;

    logic             r_a_s1, r_a_s2, r_a_h;
    logic             r_b_s1, r_b_s2, r_b_h;
    logic [1:0]       r_arm;
    logic [CNT_W-1:0] r_delta;
    logic [CNT_W-1:0] r_pos;
    logic [CNT_W-1:0] r_snap_delta;
    logic [CNT_W-1:0] r_snap_pos;
    logic             r_err;
    logic [7:0]       r_err_cnt;

    step_t                   w_dec;
    logic                    w_count_en;
    logic signed [1:0]       w_step;
    logic                    w_illegal;
    logic signed [CNT_W:0]   w_delta_sum;
    logic [CNT_W-1:0]        w_delta_next;
    logic [CNT_W-1:0]        w_pos_next;

    always_comb begin
        // The synchronizer and history hold reset zeros for the first
        // cycles after release; decoding is held off until the history
        // carries real input so no spurious step is produced.
        w_count_en  = (r_arm == 2'd3);
        w_dec       = decode_step({r_a_h, r_b_h}, {r_a_s2, r_b_s2});
        w_step      = w_count_en ? w_dec.step : 2'sb00;
        w_illegal   = w_count_en & w_dec.illegal;

        // One guard bit so the saturation check sees the true sum
        w_delta_sum = {r_delta[CNT_W-1], r_delta} + {{(CNT_W-1){w_step[1]}}, w_step};
        if (w_delta_sum > c_delta_max) begin
            w_delta_next = c_delta_max[CNT_W-1:0];
        end else if (w_delta_sum < c_delta_min) begin
            w_delta_next = c_delta_min[CNT_W-1:0];
        end else begin
            w_delta_next = w_delta_sum[CNT_W-1:0];
        end

        // Clear takes precedence over a step arriving in the same cycle
        w_pos_next = i_clr ? '0 : r_pos + {{(CNT_W-2){w_step[1]}}, w_step};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_s1       <= 1'b0;
            r_a_s2       <= 1'b0;
            r_a_h        <= 1'b0;
            r_b_s1       <= 1'b0;
            r_b_s2       <= 1'b0;
            r_b_h        <= 1'b0;
            r_arm        <= 2'd0;
            r_delta      <= '0;
            r_pos        <= '0;
            r_snap_delta <= '0;
            r_snap_pos   <= '0;
            r_err        <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_a_s1 <= i_a;
            r_a_s2 <= r_a_s1;
            r_a_h  <= r_a_s2;
            r_b_s1 <= i_b;
            r_b_s2 <= r_b_s1;
            r_b_h  <= r_b_s2;

            if (r_arm != 2'd3) begin
                r_arm <= r_arm + 2'd1;
            end

            r_pos <= w_pos_next;

            if (i_clr) begin
                r_err     <= 1'b0;
                r_err_cnt <= 8'd0;
            end else if (w_illegal) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end

            // A step landing in the terminal cycle belongs to the closing
            // window, so the snapshot takes the post-step values.
            if (i_win_end) begin
                r_snap_delta <= w_delta_next;
                r_snap_pos   <= w_pos_next;
                r_delta      <= '0;
            end else begin
                r_delta      <= w_delta_next;
            end
        end
    end

    assign o_snap_delta = r_snap_delta;
    assign o_snap_pos   = r_snap_pos;
    assign o_live_pos   = r_pos;
    assign o_err        = r_err;
    assign o_err_cnt    = r_err_cnt;

endmodule
`default_nettype wire

// File: rtl/quad_encoder_bank.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_bank
//  Description : Bank of N_CH quadrature decoders sharing one sample-window
//                counter. At each window end every channel's delta and
//                position are latched together, so a read of delta and
//                snapshot position always refers to the same window.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                enc_a, enc_b    - raw encoder phases, one bit per channel
//                clr             - per-channel position/error clear
//                sel             - read select {ch[5:2], field[1:0]}
//                rdata           - registered read data (1 cycle after sel)
//                snap_stb        - pulse after each window snapshot
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_bank
    import quad_enc_pkg::*;
#(
    parameter int N_CH       = 2,
    parameter int CNT_W      = 32,
    parameter int WINDOW     = 1_000_000,
    parameter int OFFSET_BIN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] enc_a,
    input  logic [N_CH-1:0] enc_b,
    input  logic [N_CH-1:0] clr,
    input  logic [7:0]      sel,
    output logic [31:0]     rdata,
    output logic            snap_stb
);

    localparam int                 c_win_w      = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [c_win_w-1:0] c_win_last   = c_win_w'(WINDOW - 1);
    localparam logic [CNT_W-1:0]   c_delta_bias = (OFFSET_BIN != 0) ?
                                                  {1'b1, {(CNT_W-1){1'b0}}} :
                                                  {CNT_W{1'b0}};

    logic [c_win_w-1:0]   r_win_cnt;
    logic [7:0]           r_seq;
    logic                 r_snap_stb;
    logic [31:0]          r_rdata;

    logic                 w_win_end;
    logic [32*N_CH-1:0]   w_words;
    logic [31:0]          w_rd_next;
    logic                 w_unused_sel;

    assign w_win_end    = (r_win_cnt == c_win_last);
    assign w_unused_sel = ^sel[7:6];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] w_sd;
        logic [CNT_W-1:0] w_sp;
        logic [CNT_W-1:0] w_lp;
        logic [CNT_W-1:0] w_sd_rd;
        logic             w_e;
        logic [7:0]       w_ec;

        quad_enc_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (reset),
            .i_a          (enc_a[gi]),
            .i_b          (enc_b[gi]),
            .i_clr        (clr[gi]),
            .i_win_end    (w_win_end),
            .o_snap_delta (w_sd),
            .o_snap_pos   (w_sp),
            .o_live_pos   (w_lp),
            .o_err        (w_e),
            .o_err_cnt    (w_ec)
        );

        // Offset-binary: adding 2^(CNT_W-1) maps zero delta to mid-scale
        assign w_sd_rd = w_sd + c_delta_bias;

        assign w_words[gi*32 +: 32] =
            (sel[1:0] == F_DELTA)   ? 32'(w_sd_rd) :
            (sel[1:0] == F_SNAPPOS) ? 32'(w_sp)    :
            (sel[1:0] == F_LIVEPOS) ? 32'(w_lp)    :
                                      {w_ec, 15'b0, w_e, r_seq};
    end

    // Channels outside the bank read as zero
    always_comb begin
        w_rd_next = 32'h0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel[5:2] == 4'(i)) begin
                w_rd_next = w_words[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_win_cnt  <= '0;
            r_seq      <= 8'd0;
            r_snap_stb <= 1'b0;
            r_rdata    <= 32'h0;
        end else begin
            r_snap_stb <= w_win_end;
            r_rdata    <= w_rd_next;
            if (w_win_end) begin
                r_win_cnt <= '0;
                r_seq     <= r_seq + 8'd1;
            end else begin
                r_win_cnt <= r_win_cnt + c_win_w'(1);
            end
        end
    end

    assign rdata    = r_rdata;
    assign snap_stb = r_snap_stb;

endmodule
`default_nettype wire
